// File: rtl/address_insert_tx.sv
// Source-address insertion on the TX byte stream: overwrites frame bytes
// SA_OFFSET..SA_OFFSET+5 with the station MAC latched at start of frame.
module address_insert_tx #(
    parameter int SA_OFFSET = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [47:0] mac_addr,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        inserted,
    output logic        runt
);

    // Handshake: a byte moves when in_valid & in_ready are both high at a
    // rising clk edge; out_valid/out_data mirror the input byte in the same
    // cycle, so in_ready follows out_ready except when dropping stray bytes.
    typedef enum logic [1:0] {IDLE, HDR, BODY, PASS} state_t;

    localparam logic [3:0] SA_FIRST = 4'(SA_OFFSET);
    localparam logic [3:0] SA_LAST  = 4'(SA_OFFSET + 5);

    // The state register doubles as the debug view of the frame tracker.
    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [47:0] addr_q;
    logic        pass, xfer, in_sa;
    logic [2:0]  sa_idx;
    logic [7:0]  sa_byte;
    logic        ins_next, runt_next;

    always_comb begin
        pass      = !reset && (state != IDLE || in_sof);
        xfer      = pass && in_valid && out_ready;
        in_sa     = (state == HDR) && !in_sof && (cnt >= SA_FIRST) && (cnt <= SA_LAST);
        sa_idx    = 3'(cnt - SA_FIRST);
        sa_byte   = 8'(addr_q >> {3'd5 - sa_idx, 3'b000});
        out_valid = pass && in_valid;
        out_data  = in_sa ? sa_byte : in_data;
        out_sof   = in_sof;
        out_eof   = in_eof;
        if (reset)
            in_ready = 1'b0;
        else if (pass)
            in_ready = out_ready;
        else
            in_ready = 1'b1;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ins_next   = 1'b0;
        runt_next  = 1'b0;
        if (xfer) begin
            if (in_sof) begin
                // A new SOF always restarts, abandoning any header in progress.
                cnt_next   = 4'd1;
                runt_next  = in_eof || (state == HDR);
                state_next = in_eof ? IDLE : (enable ? HDR : PASS);
            end else begin
                case (state)
                    HDR: begin
                        cnt_next = cnt + 4'd1;
                        if (cnt == SA_LAST) begin
                            ins_next   = 1'b1;
                            state_next = in_eof ? IDLE : BODY;
                        end else if (in_eof) begin
                            runt_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    BODY, PASS: begin
                        if (in_eof)
                            state_next = IDLE;
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 48'd0;
            inserted <= 1'b0;
            runt     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            inserted <= ins_next;
            runt     <= runt_next;
            if (xfer && in_sof)
                addr_q <= mac_addr;
        end
    end

endmodule

// File: tb/tb_address_insert_tx.sv
// Randomized bench for address_insert_tx: frame-level reference model feeds
// byte and pulse expectation queues that a negedge monitor drains.
module tb_address_insert_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [47:0] mac_addr = 48'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        inserted;
    logic        runt;

    localparam logic [47:0] MAC_A = 48'h0050C2853FFF;
    localparam logic [47:0] MAC_B = 48'h112233445566;

    always #5 clk = ~clk;

    address_insert_tx #(.SA_OFFSET(6)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mac_addr(mac_addr),
        .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready),
        .inserted(inserted), .runt(runt)
    );

    logic [9:0]  exp_q[$];
    logic [33:0] pulse_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;
    bit          rand_ready = 0;
    bit          gaps = 0;

    // Reference model: one open frame, its enable, address and byte count.
    bit          m_open = 0;
    bit          m_en = 0;
    logic [47:0] m_mac = 48'd0;
    int          m_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic model_accept(input logic [7:0] d, input logic s, input logic e);
        bit         r, ins;
        int         sh;
        logic [7:0] b;
        r = 0;
        ins = 0;
        if (s) begin
            if (m_open && m_en && m_len < 12)
                r = 1;
            m_open = 1;
            m_en   = enable;
            m_mac  = mac_addr;
            m_len  = 0;
        end
        if (m_open) begin
            b = d;
            if (m_en && m_len >= 6 && m_len < 12) begin
                sh = 8 * (11 - m_len);
                b  = m_mac[sh +: 8];
            end
            exp_q.push_back({s, e, b});
            if (m_en && m_len == 11)
                ins = 1;
            if (e) begin
                if (m_len == 0 || (m_en && m_len < 11))
                    r = 1;
                m_open = 0;
            end
            m_len++;
        end
        if (r || ins)
            pulse_q.push_back({32'(cyc + 1), ins, r});
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        bit done;
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        in_valid = 1'b1;
        done = 0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, s, e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: byte %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic send_frame(input int len, input bit en, input bit with_eof,
                              input logic [47:0] mac, input int chg_at,
                              input logic [47:0] mac2, input bit rnd);
        logic [7:0] d;
        enable   = en;
        mac_addr = mac;
        for (int k = 0; k < len; k++) begin
            if (k == chg_at)
                mac_addr = mac2;
            d = rnd ? 8'($urandom) : 8'(k);
            send_byte(d, k == 0, with_eof && (k == len - 1));
        end
    endtask

    // Monitor: compares outputs and pulses away from the clock edge.
    initial begin
        logic [9:0]  e;
        logic [33:0] p;
        bit          exp_i, exp_r;
        forever begin
            @(negedge clk);
            #1;
            exp_i = 0;
            exp_r = 0;
            if (reset) begin
                check("rst_out_valid", 48'(out_valid), 48'd0);
                check("rst_in_ready", 48'(in_ready), 48'd0);
                check("rst_pulses", 48'({inserted, runt}), 48'd0);
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_extra: unexpected byte %0h, none expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", 48'({out_sof, out_eof, out_data}), 48'(e));
                    end
                end
                if (in_valid && in_sof)
                    check("in_ready_sof", 48'(in_ready), 48'(out_ready));
            end
            while (pulse_q.size() > 0 && pulse_q[0][33:2] < cyc) begin
                p = pulse_q.pop_front();
                n_checks++;
                $display("FAIL pulse_missed: ins=%0b runt=%0b expected at cycle %0d, now %0d",
                         p[1], p[0], p[33:2], cyc);
            end
            if (pulse_q.size() > 0 && pulse_q[0][33:2] == cyc) begin
                p = pulse_q.pop_front();
                exp_i = p[1];
                exp_r = p[0];
            end
            if (exp_i || inserted)
                check("inserted", 48'(inserted), 48'(exp_i));
            if (exp_r || runt)
                check("runt", 48'(runt), 48'(exp_r));
            if (inserted || runt)
                check("pulse_exclusive", 48'(inserted & runt), 48'd0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] rm;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Baseline insertion, then pass-through with insertion disabled.
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 0);
        send_frame(64, 0, 1, MAC_A, -1, 48'd0, 0);

        // Back-pressure and input gaps.
        rand_ready = 1;
        gaps = 1;
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 0);
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 1);
        rand_ready = 0;
        gaps = 0;

        // Runt ending inside the address field, then a clean frame.
        send_frame(8, 1, 1, MAC_A, -1, 48'd0, 0);
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 0);

        // Address change mid-frame only takes effect at the next SOF.
        send_frame(64, 1, 1, MAC_A, 3, MAC_B, 0);
        send_frame(64, 1, 1, MAC_B, -1, 48'd0, 0);

        // Reset in the middle of a frame; stray bytes afterwards are dropped.
        send_frame(8, 1, 0, MAC_A, -1, 48'd0, 0);
        in_data  = 8'd8;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_valid = 1'b1;
        reset    = 1'b1;
        m_open   = 0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int k = 9; k < 13; k++)
            send_byte(8'(k), 1'b0, 1'b0);
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 0);

        // New SOF arriving at byte 9 of a frame still in its header.
        send_frame(9, 1, 0, MAC_A, -1, 48'd0, 0);
        send_frame(64, 1, 1, MAC_A, -1, 48'd0, 0);

        // Random frames: lengths, enables, aborts, addresses, flow control.
        for (int f = 0; f < 10; f++) begin
            rand_ready = 1'($urandom_range(0, 1));
            gaps = 1'($urandom_range(0, 1));
            rm = {16'($urandom), $urandom};
            send_frame($urandom_range(1, 24), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3) != 0, rm, -1, 48'd0, 1);
        end
        rand_ready = 0;
        gaps = 0;

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_drained", 48'(exp_q.size()), 48'd0);
        check("pulse_q_drained", 48'(pulse_q.size()), 48'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
